breakout_input_ctrl: RTL and testbench

Game-flow and paddle controller for the breakout design. It consumes the debounced left/right/start levels and a per-frame tick, and sequences the game through idle, serve, play, pause and end states. It also owns the paddle X position, with saturating movement, and the lives counter. The ball/brick logic and renderer read its outputs.

---
 rtl/breakout_input_ctrl.sv | 167 ++++++++++++++++
 tb/tb_breakout_input_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/breakout_input_ctrl.sv
// Game-flow FSM, saturating paddle position and lives counter for breakout.
// Optional paddle acceleration is built when PADDLE_ACCEL_EN is defined.
module breakout_input_ctrl #(
  parameter int unsigned PADDLE_MIN   = 0,
  parameter int unsigned PADDLE_MAX   = 600,
  parameter int unsigned PADDLE_STEP  = 4,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned ACCEL_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  output logic [9:0] paddle_x,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic       serve,
  output logic       run
);

  localparam int unsigned X_W  = 10;
  localparam int unsigned ST_W = 3;
  localparam int unsigned LV_W = 2;
  localparam int unsigned AR_W = 11;

  localparam logic [X_W-1:0]  CENTER = X_W'((PADDLE_MIN + PADDLE_MAX) / 2);
  localparam logic [X_W-1:0]  X_LO   = X_W'(PADDLE_MIN);
  localparam logic [X_W-1:0]  X_HI   = X_W'(PADDLE_MAX);
  localparam logic [AR_W-1:0] A_MIN  = AR_W'(PADDLE_MIN);
  localparam logic [AR_W-1:0] A_MAX  = AR_W'(PADDLE_MAX);
  localparam logic [AR_W-1:0] STEP1  = AR_W'(PADDLE_STEP);
  localparam logic [AR_W-1:0] STEP2  = AR_W'(2 * PADDLE_STEP);
  localparam logic [LV_W-1:0] LV_INIT = LV_W'(LIVES);

  localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] S_SERVE = 3'd1;
  localparam logic [ST_W-1:0] S_PLAY  = 3'd2;
  localparam logic [ST_W-1:0] S_PAUSE = 3'd3;
  localparam logic [ST_W-1:0] S_OVER  = 3'd4;
  localparam logic [ST_W-1:0] S_WIN   = 3'd5;

  logic            start_prev;
  logic            start_rise;
  logic [ST_W-1:0] state_n;
  logic [LV_W-1:0] lives_n;
  logic [X_W-1:0]  paddle_n;
  logic            serve_n;
  logic            run_n;
  logic            moving;
  logic            go_left;
  logic            go_right;
  logic            dbl;
  logic [AR_W-1:0] step;
  logic [AR_W-1:0] px_wide;
  logic [AR_W-1:0] px_sum;

  assign start_rise = start & ~start_prev;
  assign moving     = (state == S_SERVE) || (state == S_PLAY);
  assign go_left    = left & ~right;
  assign go_right   = right & ~left;
  assign step       = dbl ? STEP2 : STEP1;
  assign px_wide    = AR_W'(paddle_x);
  assign px_sum     = px_wide + step;

`ifdef PADDLE_ACCEL_EN
  localparam int unsigned HC_W = 6;
  logic [HC_W-1:0] hold_cnt;
  logic            hold_dir;

  assign dbl = (hold_cnt == HC_W'(ACCEL_FRAMES)) && (go_right == hold_dir);

  // Counts consecutive held frames in one direction; any break restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      hold_dir <= 1'b0;
    end else if (!moving || !(go_left ^ go_right)) begin
      hold_cnt <= '0;
    end else if (go_right != hold_dir) begin
      hold_cnt <= frame_tick ? HC_W'(1) : '0;
      hold_dir <= go_right;
    end else if (frame_tick && (hold_cnt != HC_W'(ACCEL_FRAMES))) begin
      hold_cnt <= hold_cnt + HC_W'(1);
    end
  end
`else
  assign dbl = 1'b0 & (ACCEL_FRAMES == 0);
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      paddle_x   <= CENTER;
      lives      <= '0;
      serve      <= 1'b0;
      run        <= 1'b0;
      start_prev <= 1'b1;
    end else begin
      state      <= state_n;
      paddle_x   <= paddle_n;
      lives      <= lives_n;
      serve      <= serve_n;
      run        <= run_n;
      start_prev <= start;
    end
  end

  // Next-state logic; bricks_cleared outranks ball_lost outranks start.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_rise) state_n = S_SERVE;
      S_SERVE: if (start_rise) state_n = S_PLAY;
      S_PLAY: begin
        if (bricks_cleared)  state_n = S_WIN;
        else if (ball_lost)  state_n = (lives <= 2'd1) ? S_OVER : S_SERVE;
        else if (start_rise) state_n = S_PAUSE;
      end
      S_PAUSE: if (start_rise) state_n = S_PLAY;
      S_OVER, S_WIN: if (start_rise) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Output next values; a CENTER reload overrides same-cycle movement.
  always_comb begin
    lives_n  = lives;
    paddle_n = paddle_x;
    serve_n  = 1'b0;
    run_n    = (state_n == S_PLAY);
    if (frame_tick && moving) begin
      if (go_left) begin
        if (px_wide < (A_MIN + step)) paddle_n = X_LO;
        else                          paddle_n = X_W'(px_wide - step);
      end else if (go_right) begin
        if (px_sum > A_MAX) paddle_n = X_HI;
        else                paddle_n = X_W'(px_sum);
      end
    end
    case (state)
      S_IDLE: begin
        if (start_rise) begin
          lives_n  = LV_INIT;
          paddle_n = CENTER;
        end
      end
      S_SERVE: serve_n = start_rise;
      S_PLAY: begin
        if (!bricks_cleared && ball_lost) begin
          if (lives <= 2'd1) begin
            lives_n = '0;
          end else begin
            lives_n  = lives - 2'd1;
            paddle_n = CENTER;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_breakout_input_ctrl.sv
// Scoreboard bench for breakout_input_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them in the cycle they fall due.
module tb_breakout_input_ctrl;

  localparam int STEP = 7;
  localparam int PMAX = 600;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       left = 1'b0, right = 1'b0, start = 1'b1;
  logic       frame_tick = 1'b0, ball_lost = 1'b0, bricks_cleared = 1'b0;
  logic [9:0] px;
  logic [2:0] st;
  logic [1:0] lv;
  logic       sv, rn;

  breakout_input_ctrl #(
    .PADDLE_MIN(0), .PADDLE_MAX(PMAX), .PADDLE_STEP(STEP), .LIVES(3), .ACCEL_FRAMES(30)
  ) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .start(start),
    .frame_tick(frame_tick), .ball_lost(ball_lost), .bricks_cleared(bricks_cleared),
    .paddle_x(px), .state(st), .lives(lv), .serve(sv), .run(rn)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    string      name;
    logic [2:0] st;
    logic [1:0] lv;
    logic [9:0] px;
    logic       sv;
    logic       rn;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   px_m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      cur = q.pop_front();
      n_cmp++;
      if ({st, lv, px, sv, rn} !== {cur.st, cur.lv, cur.px, cur.sv, cur.rn}) begin
        n_err++;
        $display("FAIL %s: got st=%0d lv=%0d px=%0d serve=%0b run=%0b, want st=%0d lv=%0d px=%0d serve=%0b run=%0b",
                 cur.name, st, lv, px, sv, rn, cur.st, cur.lv, cur.px, cur.sv, cur.rn);
      end
    end
  end

  task automatic drive(input bit l, input bit r, input bit s, input bit ft,
                       input bit bl, input bit bc);
    @(posedge clk);
    #1;
    left = l; right = r; start = s;
    frame_tick = ft; ball_lost = bl; bricks_cleared = bc;
  endtask

  task automatic push(input string nm, input int lag, input int s_e, input int l_e,
                      input int p_e, input bit sv_e, input bit rn_e);
    exp_t e;
    e.due = cyc + lag;
    e.name = nm;
    e.st = 3'(s_e);
    e.lv = 2'(l_e);
    e.px = 10'(p_e);
    e.sv = sv_e;
    e.rn = rn_e;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int s_e, input int l_e, input int p_e,
                     input bit sv_e, input bit rn_e);
    push(nm, 1, s_e, l_e, p_e, sv_e, rn_e);
  endtask

  // Held-direction frames with a bench-side saturating paddle model.
  task automatic move(input string nm, input bit to_left, input int n,
                      input int s_e, input int l_e);
    for (int i = 0; i < n; i++) begin
      if (to_left) px_m = (px_m >= STEP) ? px_m - STEP : 0;
      else         px_m = (px_m + STEP > PMAX) ? PMAX : px_m + STEP;
      drive(to_left, !to_left, 0, 1, 0, 0);
      chk(nm, s_e, l_e, px_m, 0, s_e == 2);
      drive(to_left, !to_left, 0, 0, 0, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    drive(0, 0, 1, 0, 0, 0); chk("reset_values", 0, 0, 300, 0, 0);
    @(posedge clk); #1 reset = 1'b1;
    drive(0, 0, 1, 0, 0, 0); chk("start_held_through_reset", 0, 0, 300, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0); chk("idle_to_serve", 1, 3, 300, 0, 0);
    drive(0, 0, 0, 0, 0, 0); chk("serve_waits", 1, 3, 300, 0, 0);
    drive(0, 0, 1, 0, 0, 0); chk("serve_to_play", 2, 3, 300, 1, 1);
    drive(0, 0, 0, 0, 0, 0); chk("serve_one_cycle", 2, 3, 300, 0, 1);
    drive(0, 0, 1, 0, 0, 0); chk("play_to_pause", 3, 3, 300, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1); chk("pause_ignores_events", 3, 3, 300, 0, 0);
    drive(1, 0, 0, 1, 0, 0); chk("pause_no_move", 3, 3, 300, 0, 0);
    drive(0, 0, 1, 0, 0, 0); chk("pause_to_play_no_serve", 2, 3, 300, 0, 1);
    drive(0, 0, 0, 0, 0, 0);

    px_m = 300;
    move("left_run", 1, 30, 2, 3);
    drive(0, 0, 0, 1, 0, 0); chk("release_no_move", 2, 3, px_m, 0, 1);
    move("left_to_min", 1, 13, 2, 3);
    move("left_at_min", 1, 1, 2, 3);
    drive(1, 1, 0, 1, 0, 0); chk("both_held", 2, 3, px_m, 0, 1);
    move("right_run", 0, 30, 2, 3);
    drive(0, 0, 0, 1, 0, 0); chk("release_right", 2, 3, px_m, 0, 1);
    move("right_run2", 0, 30, 2, 3);
    drive(0, 0, 0, 1, 0, 0);
    move("right_to_max", 0, 27, 2, 3);

    drive(0, 0, 0, 0, 1, 0); chk("lost_1", 1, 2, 300, 0, 0);
    drive(0, 0, 1, 0, 0, 0); chk("reserve_1", 2, 2, 300, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0); chk("lost_2", 1, 1, 300, 0, 0);
    drive(0, 0, 1, 0, 0, 0); chk("reserve_2", 2, 1, 300, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0); chk("lost_last_over", 4, 0, 300, 0, 0);
    drive(0, 0, 1, 0, 0, 0); chk("over_to_idle", 0, 0, 300, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    drive(0, 0, 1, 0, 0, 0); chk("new_game", 1, 3, 300, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0); chk("play_again", 2, 3, 300, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1); chk("win_priority", 5, 3, 300, 0, 0);
    drive(0, 0, 1, 0, 0, 0); chk("win_to_idle_keeps_lives", 0, 3, 300, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0); chk("idle_tick_no_move", 1, 3, 300, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0); chk("serve_tick_moves", 2, 3, 307, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 1, 0); chk("reload_beats_move", 1, 2, 300, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    px_m = 300;
    move("hold_30", 0, 30, 1, 2);
`ifdef PADDLE_ACCEL_EN
    px_m = px_m + 2 * STEP;
`else
    px_m = px_m + STEP;
`endif
    drive(0, 1, 0, 1, 0, 0); chk("hold_31", 1, 2, px_m, 0, 0);
    drive(0, 0, 0, 1, 0, 0); chk("hold_release", 1, 2, px_m, 0, 0);
    move("repress_single_step", 0, 1, 1, 2);

    @(posedge clk);
    #3 reset = 1'b0;
    push("async_reset", 0, 0, 0, 300, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
